// File: rtl/cpu_out_uart_tx_if.sv
// cpu_out_uart_tx_if: bundles the CPU result strobe and the UART/FIFO status
// outputs of cpu_out_uart_tx. The CPU side (or a bench) uses the master view.
interface cpu_out_uart_tx_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] out_in;
    logic              out_valid;
    logic              tx;
    logic              busy;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        drop_cnt;

    modport master (
        output out_in,
        output out_valid,
        input  tx,
        input  busy,
        input  fifo_full,
        input  fifo_empty,
        input  drop_cnt
    );

    modport slave (
        input  out_in,
        input  out_valid,
        output tx,
        output busy,
        output fifo_full,
        output fifo_empty,
        output drop_cnt
    );
endinterface

// File: rtl/cpu_out_uart_tx.sv
// cpu_out_uart_tx: captures each strobed CPU result word into a small FIFO and
// serialises it on an 8N1 line, least-significant byte first. Consecutive
// bytes and queued words go out back to back with no idle gap.
module cpu_out_uart_tx #(
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    cpu_out_uart_tx_if.slave bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic [PTR_W:0]    OCC_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // FIFO state
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    occ_r;
    logic [PTR_W:0]    occ_nx_s;
    logic              full_r;
    logic              empty_r;
    logic [7:0]        drop_r;

    // Serialiser state
    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_nx_s;
    logic [BYTE_W-1:0] byte_idx_r;
    logic [BYTE_W-1:0] byte_idx_nx_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_nx_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  bit_cnt_nx_s;
    logic              tx_r;
    logic              tx_nx_s;
    logic              busy_r;

    // Handshake decisions for this edge
    logic              bit_done_s;
    logic              last_byte_s;
    logic              frame_end_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [DATA_W-1:0] rd_word_s;

    assign bit_done_s  = (bit_cnt_r == BIT_LAST);
    assign last_byte_s = (byte_idx_r == BYTE_LAST);
    assign frame_end_s = (state_r == ST_STOP) && bit_done_s && last_byte_s;
    // A word leaves the FIFO when the line is idle or the previous word's last stop bit ends.
    assign pop_s       = !empty_r && ((state_r == ST_IDLE) || frame_end_s);
    // A full FIFO still accepts a word when a pop frees a slot on the same edge.
    assign push_s      = bus.out_valid && (!full_r || pop_s);
    assign drop_s      = bus.out_valid && full_r && !pop_s;
    assign rd_word_s   = mem_r[rd_ptr_r];

    // Next occupancy from the push/pop pair of this edge.
    always_comb begin
        occ_nx_s = occ_r;
        case ({push_s, pop_s})
            2'b10:   occ_nx_s = occ_r + (PTR_W + 1)'(1);
            2'b01:   occ_nx_s = occ_r - (PTR_W + 1)'(1);
            default: occ_nx_s = occ_r;
        endcase
    end

    // FIFO storage write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= bus.out_in;
        end
    end

    // FIFO pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            occ_r   <= occ_nx_s;
            full_r  <= (occ_nx_s == OCC_FULL);
            empty_r <= (occ_nx_s == '0);
        end
    end

    // Saturating count of strobes lost to overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_r <= 8'd0;
        end else if (drop_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
        end
    end

    // Serialiser next-state: frame sequencing, bit timing and the next line level.
    always_comb begin
        state_nx_s    = state_r;
        shift_nx_s    = shift_r;
        byte_idx_nx_s = byte_idx_r;
        bit_idx_nx_s  = bit_idx_r;
        bit_cnt_nx_s  = bit_cnt_r;
        case (state_r)
            ST_IDLE: begin
                bit_cnt_nx_s = '0;
                if (pop_s) begin
                    state_nx_s    = ST_START;
                    shift_nx_s    = rd_word_s;
                    byte_idx_nx_s = '0;
                    bit_idx_nx_s  = 3'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_nx_s   = ST_DATA;
                    bit_idx_nx_s = 3'd0;
                    bit_cnt_nx_s = '0;
                end else begin
                    bit_cnt_nx_s = bit_cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    bit_cnt_nx_s = '0;
                    if (bit_idx_r == 3'd7) begin
                        state_nx_s = ST_STOP;
                    end else begin
                        bit_idx_nx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    bit_cnt_nx_s = bit_cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    bit_cnt_nx_s = '0;
                    bit_idx_nx_s = 3'd0;
                    if (!last_byte_s) begin
                        // Next byte of the same word: bring it into the low byte.
                        state_nx_s    = ST_START;
                        byte_idx_nx_s = byte_idx_r + BYTE_W'(1);
                        shift_nx_s    = shift_r >> 8;
                    end else if (pop_s) begin
                        // Queued word follows immediately with no idle gap.
                        state_nx_s    = ST_START;
                        byte_idx_nx_s = '0;
                        shift_nx_s    = rd_word_s;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    bit_cnt_nx_s = bit_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                byte_idx_nx_s = '0;
                bit_idx_nx_s  = 3'd0;
                bit_cnt_nx_s  = '0;
            end
        endcase

        case (state_nx_s)
            ST_IDLE:  tx_nx_s = 1'b1;
            ST_START: tx_nx_s = 1'b0;
            ST_DATA:  tx_nx_s = shift_nx_s[bit_idx_nx_s];
            ST_STOP:  tx_nx_s = 1'b1;
            default:  tx_nx_s = 1'b1;
        endcase
    end

    // Serialiser state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            byte_idx_r <= '0;
            bit_idx_r  <= 3'd0;
            bit_cnt_r  <= '0;
        end else begin
            state_r    <= state_nx_s;
            shift_r    <= shift_nx_s;
            byte_idx_r <= byte_idx_nx_s;
            bit_idx_r  <= bit_idx_nx_s;
            bit_cnt_r  <= bit_cnt_nx_s;
        end
    end

    // Line and busy are registered so nothing combinational reaches tx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            tx_r   <= tx_nx_s;
            busy_r <= (state_nx_s != ST_IDLE);
        end
    end

    assign bus.tx         = tx_r;
    assign bus.busy       = busy_r;
    assign bus.fifo_full  = full_r;
    assign bus.fifo_empty = empty_r;
    assign bus.drop_cnt   = drop_r;
endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// tb_cpu_out_uart_tx: three instances (CLKS_PER_BIT = 4, 1, 1000) each shadowed
// by a word-queue/frame-timeline model and a UART receiver; directed tests
// pin the model with hand-computed values.
module tb_cpu_out_uart_tx;
    localparam int NI = 3;

    logic        clk;
    logic        reset;
    logic [31:0] din [NI];
    logic        dv [NI];
    logic        obs_tx [NI];
    logic        obs_busy [NI];
    logic        obs_full [NI];
    logic        obs_empty [NI];
    logic [7:0]  obs_drop [NI];
    logic [7:0]  rx_mem [NI][32];
    int          rx_n [NI];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int CPB   = (g == 0) ? 4 : ((g == 1) ? 1 : 1000);
        localparam int FRAME = 40 * CPB;

        cpu_out_uart_tx_if #(.DATA_W(32)) bus ();
        assign bus.out_in    = din[g];
        assign bus.out_valid = dv[g];
        assign obs_tx[g]     = bus.tx;
        assign obs_busy[g]   = bus.busy;
        assign obs_full[g]   = bus.fifo_full;
        assign obs_empty[g]  = bus.fifo_empty;
        assign obs_drop[g]   = bus.drop_cnt;

        cpu_out_uart_tx #(.DATA_W(32), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // Model: a queue of words plus "cycles since this word's frame began".
        logic [31:0] mq [$];
        logic [31:0] m_word = 32'd0;
        bit          m_active = 1'b0;
        int          m_el = 0;
        int          m_drop = 0;

        // Line level at a given offset into a 4-byte 8N1 frame.
        function automatic logic line_at(input logic [31:0] w, input int el);
            int p;
            int k;
            int b;
            p = el / CPB;
            k = p / 10;
            b = p % 10;
            if (b == 0) return 1'b0;
            if (b == 9) return 1'b1;
            return w[8 * k + b - 1];
        endfunction

        initial begin : model
            bit pop;
            forever begin
                @(posedge clk or negedge reset);
                if (!reset) begin
                    mq.delete();
                    m_active = 1'b0;
                    m_el     = 0;
                    m_drop   = 0;
                end else begin
                    pop = (mq.size() != 0) && (!m_active || (m_el == FRAME - 1));
                    if (pop) begin
                        m_word   = mq.pop_front();
                        m_active = 1'b1;
                        m_el     = 0;
                    end else if (m_active && (m_el == FRAME - 1)) begin
                        m_active = 1'b0;
                    end else if (m_active) begin
                        m_el++;
                    end
                    if (dv[g]) begin
                        if (mq.size() < 4) mq.push_back(din[g]);
                        else if (m_drop < 255) m_drop++;
                    end
                end
            end
        end

        initial begin : cmp
            logic [11:0] expv;
            forever begin
                @(negedge clk);
                expv = {(m_active ? line_at(m_word, m_el) : 1'b1), m_active,
                        (mq.size() == 4), (mq.size() == 0), 8'(m_drop)};
                chk($sformatf("cycle_outputs_inst%0d", g),
                    32'({obs_tx[g], obs_busy[g], obs_full[g], obs_empty[g], obs_drop[g]}),
                    32'(expv));
            end
        end

        initial begin : rx
            int r_cnt;
            bit r_act;
            logic [7:0] r_byte;
            r_cnt = 0;
            r_act = 1'b0;
            r_byte = 8'd0;
            forever begin
                @(negedge clk);
                if (!reset) begin
                    r_act = 1'b0;
                end else begin
                    if (r_act) r_cnt++;
                    else if (obs_tx[g] == 1'b0) begin
                        r_act  = 1'b1;
                        r_cnt  = 0;
                        r_byte = 8'd0;
                    end
                    if (r_act) begin
                        if (r_cnt >= CPB && r_cnt < 9 * CPB && (r_cnt % CPB) == CPB / 2)
                            r_byte[(r_cnt - CPB) / CPB] = obs_tx[g];
                        if (r_cnt == 9 * CPB + CPB / 2) begin
                            chk($sformatf("rx_stop_bit_inst%0d", g), 32'(obs_tx[g]), 32'd1);
                            if (rx_n[g] < 32) rx_mem[g][rx_n[g]] = r_byte;
                            rx_n[g]++;
                        end
                        if (r_cnt == 10 * CPB - 1) r_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int i, input logic [31:0] v);
        din[i] = v;
        dv[i]  = 1'b1;
        tick();
        dv[i]  = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int limit);
        int n;
        n = 0;
        while (!(obs_busy[i] == 1'b0 && obs_empty[i] == 1'b1) && n < limit) begin
            tick();
            n++;
        end
        chk("idle_within_budget", 32'(n < limit), 32'd1);
    endtask

    task automatic wait_bytes(input int i, input int cnt, input int limit);
        int n;
        n = 0;
        while (rx_n[i] < cnt && n < limit) begin
            tick();
            n++;
        end
        chk("rx_byte_count", 32'(rx_n[i]), 32'(cnt));
    endtask

    initial begin
        int n;
        int n_low;
        int consec;
        logic prev;
        int unsigned t1;
        int unsigned pa;
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            din[i]  = 32'd0;
            dv[i]   = 1'b0;
            rx_n[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx", 32'(obs_tx[0]), 32'd1);
        chk("reset_busy", 32'(obs_busy[0]), 32'd0);
        chk("reset_full", 32'(obs_full[0]), 32'd0);
        chk("reset_empty", 32'(obs_empty[0]), 32'd1);
        chk("reset_drop", 32'(obs_drop[0]), 32'd0);
        reset = 1'b1;
        tick();

        // Single word
        strobe(0, 32'hA5C30F81);
        chk("t1_tx_before_start", 32'(obs_tx[0]), 32'd1);
        chk("t1_not_empty", 32'(obs_empty[0]), 32'd0);
        tick();
        chk("t1_tx_fall", 32'(obs_tx[0]), 32'd0);
        chk("t1_busy_rise", 32'(obs_busy[0]), 32'd1);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (obs_busy[0]) n++;
            else break;
        end
        chk("t1_busy_len", 32'(n), 32'd160);
        chk("t1_tx_idle", 32'(obs_tx[0]), 32'd1);
        chk("t1_empty_after", 32'(obs_empty[0]), 32'd1);
        wait_bytes(0, 4, 50);
        chk("t1_byte0", 32'(rx_mem[0][0]), 32'h81);
        chk("t1_byte1", 32'(rx_mem[0][1]), 32'h0F);
        chk("t1_byte2", 32'(rx_mem[0][2]), 32'hC3);
        chk("t1_byte3", 32'(rx_mem[0][3]), 32'hA5);

        // Overflow: six back-to-back strobes, word 6 lost
        rx_n[0] = 0;
        t1 = 0;
        for (int v = 1; v <= 6; v++) begin
            strobe(0, 32'(v));
            if (v == 2) t1 = cyc;
        end
        chk("t2_drop", 32'(obs_drop[0]), 32'd1);
        chk("t2_full", 32'(obs_full[0]), 32'd1);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!obs_busy[0]) break;
        end
        chk("t2_busy_span", cyc - t1, 32'd800);
        wait_bytes(0, 20, 50);
        for (int k = 0; k < 20; k++)
            chk($sformatf("t2_byte%0d", k), 32'(rx_mem[0][k]), (k % 4 == 0) ? 32'(k / 4 + 1) : 32'd0);
        wait_idle(0, 200);

        // Push on the exact edge where the last stop bit pops
        rx_n[0] = 0;
        strobe(0, 32'h11111111);
        pa = cyc;
        for (int v = 2; v <= 5; v++) strobe(0, 32'h11111111 * 32'(v));
        chk("t3_full_before", 32'(obs_full[0]), 32'd1);
        while (cyc < pa + 160) tick();
        chk("t3_full_at_edge", 32'(obs_full[0]), 32'd1);
        strobe(0, 32'h66666666);
        chk("t3_full_kept", 32'(obs_full[0]), 32'd1);
        chk("t3_drop_kept", 32'(obs_drop[0]), 32'd1);
        chk("t3_next_start", 32'(obs_tx[0]), 32'd0);
        wait_bytes(0, 24, 1200);
        for (int k = 0; k < 24; k++)
            chk($sformatf("t3_byte%0d", k), 32'(rx_mem[0][k]), 32'h11 * 32'(k / 4 + 1));
        wait_idle(0, 200);

        // Asynchronous reset in DATA bit 3 of byte 2 with 3 words queued
        strobe(0, 32'h12345678);
        pa = cyc;
        for (int v = 0; v < 3; v++) strobe(0, 32'h12345678);
        while (cyc < pa + 1 + 97) tick();
        chk("t4_busy_pre", 32'(obs_busy[0]), 32'd1);
        chk("t4_tx_pre", 32'(obs_tx[0]), 32'd0);
        chk("t4_drop_pre", 32'(obs_drop[0]), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t4_tx_async", 32'(obs_tx[0]), 32'd1);
        chk("t4_busy_async", 32'(obs_busy[0]), 32'd0);
        chk("t4_empty_async", 32'(obs_empty[0]), 32'd1);
        chk("t4_full_async", 32'(obs_full[0]), 32'd0);
        chk("t4_drop_async", 32'(obs_drop[0]), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        rx_n[0] = 0;
        tick();
        strobe(0, 32'h00000055);
        wait_bytes(0, 4, 300);
        chk("t4_byte0", 32'(rx_mem[0][0]), 32'h55);
        chk("t4_byte1", 32'(rx_mem[0][1]), 32'h00);
        chk("t4_byte2", 32'(rx_mem[0][2]), 32'h00);
        chk("t4_byte3", 32'(rx_mem[0][3]), 32'h00);
        wait_idle(0, 200);

        // CLKS_PER_BIT = 1, all-ones word
        rx_n[1] = 0;
        strobe(1, 32'hFFFFFFFF);
        tick();
        chk("t5_tx_fall", 32'(obs_tx[1]), 32'd0);
        n = 0;
        n_low = 0;
        consec = 0;
        prev = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!obs_busy[1]) break;
            n++;
            if (!obs_tx[1]) begin
                n_low++;
                if (!prev) consec++;
            end
            prev = obs_tx[1];
        end
        chk("t5_frame_len", 32'(n), 32'd40);
        chk("t5_low_cycles", 32'(n_low), 32'd4);
        chk("t5_low_runs", 32'(consec), 32'd0);
        wait_bytes(1, 4, 20);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t5_byte%0d", k), 32'(rx_mem[1][k]), 32'hFF);

        // drop_cnt saturation with CLKS_PER_BIT = 1000
        for (int k = 1; k <= 300; k++) begin
            strobe(2, 32'(k));
            if (k == 5)   chk("t6_full", 32'(obs_full[2]), 32'd1);
            if (k == 6)   chk("t6_drop_first", 32'(obs_drop[2]), 32'd1);
            if (k == 259) chk("t6_drop_254", 32'(obs_drop[2]), 32'd254);
            if (k == 260) chk("t6_drop_255", 32'(obs_drop[2]), 32'd255);
        end
        chk("t6_drop_sat", 32'(obs_drop[2]), 32'd255);
        chk("t6_full_held", 32'(obs_full[2]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
